// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - SYNC/LEN/payload/CHK frame hunter with checksum-gated payload release
module uart_rx_deframer #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_PAYLOAD    = 16,
    parameter int         TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_data_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic [7:0] err_count,
    output logic [7:0] drop_count,
    output logic       busy
);

    localparam int PTR_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0]       MAX_LEN  = 8'(MAX_PAYLOAD);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       sum_q, sum_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [7:0]       err_q, err_d;
    logic [7:0]       drop_q, drop_d;
    logic [7:0]       pay_q [MAX_PAYLOAD];
    logic [7:0]       pay_d [MAX_PAYLOAD];

    logic byte_evt;
    logic timed_out;
    logic wr_last;
    logic rd_last;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A byte is a rising edge of the receiver's valid, so pulses and held levels both count once.
    assign byte_evt  = rx_data_valid & ~valid_q;
    assign timed_out = (timer_q == TMR_LAST);
    assign wr_last   = (LEN_W'(wr_ptr_q) == len_q - LEN_W'(1));
    assign rd_last   = (LEN_W'(rd_ptr_q) == len_q - LEN_W'(1));

    assign out_valid  = (state_q == S_DRAIN);
    assign out_data   = out_valid ? pay_q[rd_ptr_q] : 8'h00;
    assign out_last   = out_valid & rd_last;
    assign err_count  = err_q;
    assign drop_count = drop_q;
    assign busy       = (state_q != S_HUNT);

    // Next-state: frame parsing, inter-byte timeout, buffered drain and saturating counters.
    always_comb begin
        state_d  = state_q;
        valid_d  = rx_data_valid;
        len_d    = len_q;
        sum_d    = sum_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        timer_d  = timer_q;
        err_d    = err_q;
        drop_d   = drop_q;
        pay_d    = pay_q;

        case (state_q)
            S_HUNT: begin
                timer_d = '0;
                if (byte_evt && rx_data == SYNC_BYTE) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                timer_d = timer_q + TMR_W'(1);
                if (byte_evt) begin
                    timer_d = '0;
                    if (rx_data != 8'h00 && rx_data <= MAX_LEN) begin
                        len_d    = rx_data[LEN_W-1:0];
                        sum_d    = rx_data;
                        wr_ptr_d = '0;
                        state_d  = S_PAYLOAD;
                    end else begin
                        err_d   = sat_inc(err_q);
                        state_d = S_HUNT;
                    end
                end else if (timed_out) begin
                    err_d   = sat_inc(err_q);
                    state_d = S_HUNT;
                end
            end
            S_PAYLOAD: begin
                timer_d = timer_q + TMR_W'(1);
                if (byte_evt) begin
                    timer_d          = '0;
                    pay_d[wr_ptr_q]  = rx_data;
                    sum_d            = sum_q ^ rx_data;
                    wr_ptr_d         = wr_ptr_q + PTR_W'(1);
                    if (wr_last) begin
                        state_d = S_CHK;
                    end
                end else if (timed_out) begin
                    err_d   = sat_inc(err_q);
                    state_d = S_HUNT;
                end
            end
            S_CHK: begin
                timer_d = timer_q + TMR_W'(1);
                if (byte_evt) begin
                    timer_d = '0;
                    if (rx_data == sum_q) begin
                        rd_ptr_d = '0;
                        state_d  = S_DRAIN;
                    end else begin
                        err_d   = sat_inc(err_q);
                        state_d = S_HUNT;
                    end
                end else if (timed_out) begin
                    err_d   = sat_inc(err_q);
                    state_d = S_HUNT;
                end
            end
            S_DRAIN: begin
                timer_d = '0;
                if (byte_evt) begin
                    drop_d = sat_inc(drop_q);
                end
                if (out_ready) begin
                    if (rd_last) begin
                        state_d = S_HUNT;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase
    end

    // State register; valid_q resets high so a level held through reset is not a byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_HUNT;
            valid_q  <= 1'b1;
            len_q    <= '0;
            sum_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            timer_q  <= '0;
            err_q    <= '0;
            drop_q   <= '0;
            pay_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            len_q    <= len_d;
            sum_q    <= sum_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
            drop_q   <= drop_d;
            pay_q    <= pay_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - directed and randomized frame checks against a frame-level model
module tb_uart_rx_deframer;

    localparam int TO   = 10000;
    localparam int MAXP = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic [7:0] err_count;
    logic [7:0] drop_count;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int exp_err = 0;
    int exp_drop = 0;

    logic [8:0] got_q [$];
    logic [8:0] exp_q [$];
    logic [7:0] tx_q  [$];

    uart_rx_deframer #(
        .SYNC_BYTE(8'hA5),
        .MAX_PAYLOAD(MAXP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_data_valid(rx_data_valid),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_last(out_last),
        .out_ready(out_ready),
        .err_count(err_count),
        .drop_count(drop_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Record every accepted output byte just before the edge that takes it.
    always @(negedge clk) begin
        #4;
        if (!rst && out_valid && out_ready) begin
            got_q.push_back({out_last, out_data});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data       = b;
        rx_data_valid = 1'b1;
        @(negedge clk);
        rx_data_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_tx();
        foreach (tx_q[i]) send_byte(tx_q[i]);
        tx_q.delete();
    endtask

    // Model of a well-formed frame: payload emerges in order, last flag on the final byte.
    task automatic model_frame(input int len, input bit corrupt);
        logic [7:0] p;
        logic [7:0] x;
        x = 8'(len);
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            p = 8'($urandom_range(0, 255));
            x = x ^ p;
            tx_q.push_back(p);
            if (!corrupt) exp_q.push_back({(i == len - 1), p});
        end
        if (corrupt) begin
            x = x ^ 8'($urandom_range(1, 255));
            exp_err++;
        end
        tx_q.push_back(x);
    endtask

    task automatic check_stream(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_byte"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int kind;
        int len;
        rst           = 1'b1;
        rx_data       = 8'h00;
        rx_data_valid = 1'b0;
        out_ready     = 1'b1;
        idle(3);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_err", err_count, 0);
        check("rst_drop", drop_count, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        idle(2);

        tx_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        exp_q = {9'h011, 9'h022, 9'h133};
        send_tx();
        idle(20);
        check_stream("good");
        check("good_err", err_count, 0);
        check("good_busy", busy, 0);

        tx_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
        exp_err++;
        send_tx();
        idle(20);
        check_stream("badchk");
        check("badchk_err", err_count, exp_err);
        tx_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        exp_q = {9'h011, 9'h022, 9'h133};
        send_tx();
        idle(20);
        check_stream("after_badchk");

        tx_q = {8'hA5, 8'h00};
        exp_err++;
        send_tx();
        check("len0_err", err_count, exp_err);
        tx_q = {8'hA5, 8'h11, 8'h22, 8'h33};
        exp_err++;
        send_tx();
        check("len17_err", err_count, exp_err);
        check("len17_busy", busy, 0);
        tx_q = {8'hA5, 8'hA5};
        exp_err++;
        send_tx();
        check("double_sync_err", err_count, exp_err);
        idle(5);
        check_stream("lenerr");

        tx_q = {8'hA5, 8'h02, 8'h44};
        send_tx();
        idle(TO - 2);
        check("timeout_edge_busy", busy, 1);
        idle(1);
        exp_err++;
        check("timeout_busy", busy, 0);
        check("timeout_err", err_count, exp_err);
        tx_q = {8'hA5, 8'h01, 8'h55, 8'h54};
        exp_q = {9'h155};
        send_tx();
        idle(10);
        check_stream("after_timeout");

        out_ready = 1'b0;
        tx_q = {8'hA5, 8'h02, 8'h01, 8'h02, 8'h01};
        send_tx();
        tx_q = {8'hA5, 8'hA5};
        send_tx();
        exp_drop += 2;
        idle(4);
        check("bp_drop", drop_count, exp_drop);
        check("bp_valid", out_valid, 1);
        check("bp_data", out_data, 8'h01);
        check("bp_last", out_last, 0);
        check("bp_nothing_taken", got_q.size(), 0);
        out_ready = 1'b1;
        exp_q = {9'h001, 9'h102};
        idle(10);
        check_stream("bp_release");
        check("bp_busy", busy, 0);
        check("bp_err", err_count, exp_err);

        tx_q = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h77, 8'h76};
        exp_q = {9'h177};
        send_tx();
        idle(10);
        check_stream("garbage");
        check("garbage_err", err_count, exp_err);

        tx_q = {8'hA5, 8'h04, 8'h10};
        send_tx();
        @(negedge clk);
        rx_data       = 8'hA5;
        rx_data_valid = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(4);
        exp_err  = 0;
        exp_drop = 0;
        check("midrst_busy", busy, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_last", out_last, 0);
        check("midrst_data", out_data, 0);
        check("midrst_err", err_count, 0);
        check("midrst_drop", drop_count, 0);
        rx_data_valid = 1'b0;
        tx_q = {8'h01, 8'h33, 8'h32};
        send_tx();
        idle(4);
        check("midrst_no_frame_busy", busy, 0);
        check_stream("midrst_held");
        tx_q = {8'hA5, 8'h01, 8'h33, 8'h32};
        exp_q = {9'h133};
        send_tx();
        idle(10);
        check_stream("midrst_after");

        for (int it = 0; it < 25; it++) begin
            kind = $urandom_range(0, 3);
            len  = $urandom_range(1, MAXP);
            if (kind == 3) begin
                for (int g = 0; g < $urandom_range(1, 3); g++) begin
                    tx_q.push_back(8'($urandom_range(0, 255)) & 8'h7F);
                end
            end
            if (kind == 2) begin
                tx_q.push_back(8'hA5);
                tx_q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXP + 1, 255)));
                exp_err++;
            end else begin
                model_frame(len, kind == 1);
            end
            send_tx();
            idle(24);
            check_stream("rand");
            check("rand_err", err_count, exp_err);
            check("rand_busy", busy, 0);
        end
        check("rand_drop", drop_count, exp_drop);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
